// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
//  Shared types for the integer register-file write-back slice.
//  XLEN       : data width of results and of the register file
//  reg_idx_t  : architectural register index (x0..x31)
//  wb_entry_t : one pending write-back result {rd, data}
// ----------------------------------------------------------------------------
package rv32_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   typedef logic [4:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t          rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

endpackage : rv32_pkg

// File: rtl/rf_wb_fifo.sv
// ----------------------------------------------------------------------------
// rf_wb_fifo
//  Synchronous FIFO of wb_entry_t used to hold load results waiting for the
//  register-file write port. Only the pointers are reset; the storage is not.
//  The head entry is presented combinationally so it can be popped straight
//  into the write-port register in the same cycle.
// Ports
//  clk, rst_n   clock, asynchronous active-low reset
//  push_i       write din_i at the tail (caller guarantees !full_o)
//  din_i        entry to push
//  pop_i        drop the head entry (caller guarantees !empty_o)
//  dout_o       current head entry
//  full_o       all DEPTH entries occupied
//  empty_o      no entries
// ----------------------------------------------------------------------------
module rf_wb_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push_i,
   input  wb_entry_t din_i,
   input  logic      pop_i,
   output wb_entry_t dout_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int IW = (AW > 0) ? AW : 1;
   // One extra pointer bit distinguishes full from empty when indices match.
   localparam int PW = AW + 1;

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [IW-1:0]   wr_idx, rd_idx;

   generate
      if (AW > 0) begin : g_idx
         assign wr_idx = wr_ptr_q[IW-1:0];
         assign rd_idx = rd_ptr_q[IW-1:0];
      end else begin : g_idx_single
         assign wr_idx = '0;
         assign rd_idx = '0;
      end
   endgenerate

   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   // MSBs differ and index bits equal <=> pointer XOR equals DEPTH.
   assign full_o   = ((wr_ptr_q ^ rd_ptr_q) == PW'(DEPTH));
   assign dout_o   = mem[rd_idx];

   assign wr_ptr_d = push_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
   assign rd_ptr_d = pop_i  ? rd_ptr_q + PW'(1) : rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         mem[wr_idx] <= din_i;
      end
   end

endmodule : rf_wb_fifo

// File: rtl/rf_writeback.sv
// ----------------------------------------------------------------------------
// rf_writeback
//  Write-side driver of the integer register file. Merges single-cycle ALU
//  results and queued multi-cycle load results onto the single write port and
//  keeps a pending-write scoreboard for decode hazard checks.
//  Data width is rv32_pkg::XLEN.
// Ports
//  clk, rst_n                  clock, asynchronous active-low reset
//  issue_valid/long/rd         instruction issue; long => rd written by a load
//  issue_rd_busy               pending[issue_rd] (WAW), 0 for x0
//  rs1, rs2 / rs1_busy,rs2_busy source hazard queries, 0 for x0
//  alu_valid/rd/data           ALU result, never stalled
//  load_valid/rd/data          load result offer; load_ready = queue not full
//  rf_wr/rf_rd/rf_wrdata       registered register-file write port
// ----------------------------------------------------------------------------
module rf_writeback
   import rv32_pkg::*;
#(
   parameter int LQ_DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic             issue_long,
   input  logic [4:0]       issue_rd,
   output logic             issue_rd_busy,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic             rs1_busy,
   output logic             rs2_busy,
   input  logic             alu_valid,
   input  logic [4:0]       alu_rd,
   input  logic [XLEN-1:0]  alu_data,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [4:0]       load_rd,
   input  logic [XLEN-1:0]  load_data,
   output logic             rf_wr,
   output logic [4:0]       rf_rd,
   output logic [XLEN-1:0]  rf_wrdata
);

   // ---------------------------------------------------------------- select
   wb_entry_t        fifo_din, fifo_head;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic             alu_win, load_xfer, load_keep, bypass;

   assign alu_win    = alu_valid && (alu_rd != '0);
   assign load_ready = !fifo_full;
   assign load_xfer  = load_valid && load_ready;
   // rd==0 loads are accepted but never stored or written.
   assign load_keep  = load_xfer && (load_rd != '0);
   assign fifo_pop   = !alu_win && !fifo_empty;
   // Bypass only when nothing older is queued, which keeps loads in order.
   assign bypass     = !alu_win && fifo_empty && load_keep;
   assign fifo_push  = load_keep && !bypass;
   assign fifo_din   = '{rd: load_rd, data: load_data};

   rf_wb_fifo #(
      .DEPTH   (LQ_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .din_i   (fifo_din),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // ------------------------------------------------------- write-port reg
   logic             rf_wr_q, rf_wr_d;
   logic [4:0]       rf_rd_q, rf_rd_d;
   logic [XLEN-1:0]  rf_wrdata_q, rf_wrdata_d;
   logic             src_load_q, src_load_d;

   always_comb begin
      rf_wr_d     = 1'b0;
      rf_rd_d     = rf_rd_q;
      rf_wrdata_d = rf_wrdata_q;
      src_load_d  = src_load_q;
      if (alu_win) begin
         rf_wr_d     = 1'b1;
         rf_rd_d     = alu_rd;
         rf_wrdata_d = alu_data;
         src_load_d  = 1'b0;
      end else if (fifo_pop) begin
         rf_wr_d     = 1'b1;
         rf_rd_d     = fifo_head.rd;
         rf_wrdata_d = fifo_head.data;
         src_load_d  = 1'b1;
      end else if (bypass) begin
         rf_wr_d     = 1'b1;
         rf_rd_d     = load_rd;
         rf_wrdata_d = load_data;
         src_load_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wr_q     <= 1'b0;
         rf_rd_q     <= '0;
         rf_wrdata_q <= '0;
         src_load_q  <= 1'b0;
      end else begin
         rf_wr_q     <= rf_wr_d;
         rf_rd_q     <= rf_rd_d;
         rf_wrdata_q <= rf_wrdata_d;
         src_load_q  <= src_load_d;
      end
   end

   assign rf_wr     = rf_wr_q;
   assign rf_rd     = rf_rd_q;
   assign rf_wrdata = rf_wrdata_q;

   // ------------------------------------------------------------ scoreboard
   // A bit clears on the edge the register file captures the load data, so
   // busy falls exactly when the value becomes readable. Set beats clear.
   logic [NREGS-1:1] pending_q, pending_d;
   logic [NREGS-1:0] pend_vec;
   logic             set_en, clr_en;

   assign set_en = issue_valid && issue_long;
   assign clr_en = rf_wr_q && src_load_q;

   genvar gi;
   generate
      for (gi = 1; gi < NREGS; gi++) begin : g_pend
         assign pending_d[gi] = (set_en && (issue_rd == reg_idx_t'(gi))) ||
                                (pending_q[gi] && !(clr_en && (rf_rd_q == reg_idx_t'(gi))));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // Bit 0 is hard-wired low so x0 queries never report busy.
   assign pend_vec      = {pending_q, 1'b0};
   assign issue_rd_busy = pend_vec[issue_rd];
   assign rs1_busy      = pend_vec[rs1];
   assign rs2_busy      = pend_vec[rs2];

   // ------------------------------------------------------ protocol checks
   // Re-issuing to an rd whose load is being written back on this very edge
   // is tolerated: the set takes effect after the clear.
   a_no_waw_issue: assert property (@(posedge clk) disable iff (!rst_n)
      (issue_valid && issue_long && issue_rd_busy) |-> (clr_en && (rf_rd_q == issue_rd)));

   a_alu_not_pending: assert property (@(posedge clk) disable iff (!rst_n)
      alu_win |-> !pend_vec[alu_rd]);

   a_load_pending: assert property (@(posedge clk) disable iff (!rst_n)
      load_keep |-> pend_vec[load_rd]);

endmodule : rf_writeback

// File: tb/tb_rf_writeback.sv
// ----------------------------------------------------------------------------
// tb_rf_writeback
//  Self-checking bench for rf_writeback. Each cycle a small reference model of
//  the write-back priority and load queue predicts the write-port contents;
//  the prediction goes to a scoreboard queue and is compared after the edge.
//  Hazard flags are checked directly at the points where they must change.
// ----------------------------------------------------------------------------
module tb_rf_writeback;

   localparam int LQ_DEPTH = 2;

   typedef struct {
      logic        wr;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ld_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        issue_valid, issue_long;
   logic [4:0]  issue_rd, rs1, rs2;
   logic        issue_rd_busy, rs1_busy, rs2_busy;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        load_valid, load_ready;
   logic [4:0]  load_rd;
   logic [31:0] load_data;
   logic        rf_wr;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wrdata;

   int          n_checks = 0;
   int          n_errors = 0;

   exp_t        exp_q[$];
   ld_t         m_lq[$];
   logic [4:0]  m_last_rd;
   logic [31:0] m_last_data;

   always #5 clk = ~clk;

   rf_writeback #(
      .LQ_DEPTH      (LQ_DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid   (issue_valid),
      .issue_long    (issue_long),
      .issue_rd      (issue_rd),
      .issue_rd_busy (issue_rd_busy),
      .rs1           (rs1),
      .rs2           (rs2),
      .rs1_busy      (rs1_busy),
      .rs2_busy      (rs2_busy),
      .alu_valid     (alu_valid),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .load_valid    (load_valid),
      .load_ready    (load_ready),
      .load_rd       (load_rd),
      .load_data     (load_data),
      .rf_wr         (rf_wr),
      .rf_rd         (rf_rd),
      .rf_wrdata     (rf_wrdata)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      issue_valid = 1'b0;
      issue_long  = 1'b0;
      issue_rd    = '0;
      alu_valid   = 1'b0;
      alu_rd      = '0;
      alu_data    = '0;
      load_valid  = 1'b0;
      load_rd     = '0;
      load_data   = '0;
   endtask

   // One clock cycle: predict the selection, push it, clock, pop and compare.
   task automatic tick();
      exp_t e;
      exp_t got;
      logic ready_exp;
      logic xfer;
      ready_exp = (m_lq.size() < LQ_DEPTH);
      check("load_ready", 64'(load_ready), 64'(ready_exp));
      xfer = load_valid && ready_exp;
      e.wr = 1'b1;
      if (alu_valid && alu_rd != 5'd0) begin
         e.rd = alu_rd; e.data = alu_data;
         if (xfer && load_rd != 5'd0) m_lq.push_back('{rd: load_rd, data: load_data});
      end else if (m_lq.size() > 0) begin
         ld_t h;
         h = m_lq.pop_front();
         e.rd = h.rd; e.data = h.data;
         if (xfer && load_rd != 5'd0) m_lq.push_back('{rd: load_rd, data: load_data});
      end else if (xfer && load_rd != 5'd0) begin
         e.rd = load_rd; e.data = load_data;
      end else begin
         e.wr = 1'b0; e.rd = m_last_rd; e.data = m_last_data;
      end
      m_last_rd   = e.rd;
      m_last_data = e.data;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 64'(1), 64'(0));
      end else begin
         got = exp_q.pop_front();
         check("rf_wr", 64'(rf_wr), 64'(got.wr));
         check("rf_rd", 64'(rf_rd), 64'(got.rd));
         check("rf_wrdata", 64'(rf_wrdata), 64'(got.data));
         $display("cycle t=%0t wr=%0b rd=%0d data=0x%08h (exp wr=%0b rd=%0d data=0x%08h)",
                  $time, rf_wr, rf_rd, rf_wrdata, got.wr, got.rd, got.data);
      end
   endtask

   task automatic issue_long_rd(input logic [4:0] rd);
      clear_inputs();
      issue_valid = 1'b1;
      issue_long  = 1'b1;
      issue_rd    = rd;
      tick();
      clear_inputs();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [4:0]  ld_rds   [3];
      logic [31:0] ld_datas [3];
      int          li;
      int          budget;

      clear_inputs();
      rs1 = '0;
      rs2 = '0;
      rst_n = 1'b0;
      m_last_rd = '0;
      m_last_data = '0;
      #1;
      check("rst_rf_wr", 64'(rf_wr), 64'(0));
      check("rst_rf_rd", 64'(rf_rd), 64'(0));
      check("rst_rf_wrdata", 64'(rf_wrdata), 64'(0));
      check("rst_load_ready", 64'(load_ready), 64'(1));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: long issue rd5, hazard visible, load write-back clears it.
      issue_long_rd(5'd5);
      rs1 = 5'd5;
      #1;
      check("t1_rs1_busy_set", 64'(rs1_busy), 64'(1));
      load_valid = 1'b1; load_rd = 5'd5; load_data = 32'hA5A5_0001;
      tick();
      check("t1_rs1_busy_during_wr", 64'(rs1_busy), 64'(1));
      clear_inputs();
      tick();
      check("t1_rs1_busy_clear", 64'(rs1_busy), 64'(0));

      // 2: ALU and load in the same cycle: ALU first, load next.
      issue_long_rd(5'd7);
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      load_valid = 1'b1; load_rd = 5'd7; load_data = 32'h22;
      tick();
      clear_inputs();
      tick();
      tick();

      // 3: ALU busy 4 cycles while 3 loads arrive; queue fills, drains in order.
      ld_rds   = '{5'd10, 5'd11, 5'd12};
      ld_datas = '{32'hC0DE_000A, 32'hC0DE_000B, 32'hC0DE_000C};
      for (int i = 0; i < 3; i++) issue_long_rd(ld_rds[i]);
      li = 0;
      for (int c = 0; c < 4; c++) begin
         alu_valid = 1'b1; alu_rd = 5'(c + 1); alu_data = 32'h100 + 32'(c);
         load_valid = (li < 3);
         load_rd    = (li < 3) ? ld_rds[li] : 5'd0;
         load_data  = (li < 3) ? ld_datas[li] : 32'd0;
         if (load_valid && m_lq.size() < LQ_DEPTH) begin
            tick(); li++;
         end else begin
            tick();
         end
      end
      clear_inputs();
      budget = 10;
      while (li < 3 && budget > 0) begin
         load_valid = 1'b1; load_rd = ld_rds[li]; load_data = ld_datas[li];
         if (m_lq.size() < LQ_DEPTH) begin
            tick(); li++;
         end else begin
            tick();
         end
         budget--;
      end
      check("t3_all_loads_accepted", 64'(li), 64'(3));
      clear_inputs();
      repeat (4) tick();

      // 4: rd0 results are discarded, rd0 load is accepted.
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
      load_valid = 1'b1; load_rd = 5'd0; load_data = 32'hBEEF;
      rs1 = 5'd0; rs2 = 5'd0;
      tick();
      clear_inputs();
      check("t4_rs1_x0_busy", 64'(rs1_busy), 64'(0));
      tick();

      // 5: clear and re-issue of rd9 on the same edge -> pending stays set.
      issue_long_rd(5'd9);
      load_valid = 1'b1; load_rd = 5'd9; load_data = 32'h0000_0999;
      tick();
      clear_inputs();
      issue_valid = 1'b1; issue_long = 1'b1; issue_rd = 5'd9;
      tick();
      clear_inputs();
      rs2 = 5'd9;
      #1;
      check("t5_rs2_busy_kept", 64'(rs2_busy), 64'(1));

      // 6: asynchronous reset with two queued loads.
      issue_long_rd(5'd20);
      issue_long_rd(5'd21);
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      load_valid = 1'b1; load_rd = 5'd20; load_data = 32'h2020;
      tick();
      alu_rd = 5'd2; alu_data = 32'h2;
      load_rd = 5'd21; load_data = 32'h2121;
      tick();
      clear_inputs();
      rs1 = 5'd20; rs2 = 5'd21; issue_rd = 5'd20;
      #1;
      check("t6_pre_load_ready", 64'(load_ready), 64'(0));
      #1;
      rst_n = 1'b0;
      #1;
      check("t6_rst_rf_wr", 64'(rf_wr), 64'(0));
      check("t6_rst_load_ready", 64'(load_ready), 64'(1));
      check("t6_rst_rs1_busy", 64'(rs1_busy), 64'(0));
      check("t6_rst_rs2_busy", 64'(rs2_busy), 64'(0));
      check("t6_rst_issue_rd_busy", 64'(issue_rd_busy), 64'(0));
      m_lq.delete();
      m_last_rd = '0;
      m_last_data = '0;
      @(posedge clk);
      #1;
      check("t6_rst_next_rf_wr", 64'(rf_wr), 64'(0));
      check("t6_rst_next_rf_rd", 64'(rf_rd), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      check("t6_post_rs2_busy", 64'(rs2_busy), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_rf_writeback
